// File: rtl/btb_pkg.sv
// Shared types and width helpers for the BTB update controller.
// Holds the controller state encoding and the queued update record.
package btb_pkg;

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } btb_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } btb_upd_t;

    localparam int BTB_PC_W     = 32;
    localparam int BTB_WORD_BITS = BTB_PC_W - 2;

    function automatic int btb_idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int btb_tag_w(input int n);
        return BTB_WORD_BITS - $clog2(n);
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue: QDEPTH-entry FIFO, registered head, no pass-through; push at full accepted only with a pop.
// discard empties the queue in one cycle; occupancy counter separates full from empty.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter  int QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  btb_upd_t       push_dat,
    input  logic           pop,
    output btb_upd_t       pop_dat,
    output logic           full,
    output logic           empty,
    output logic [CW-1:0]  count,
    input  logic           discard
);

    btb_upd_t      mem_q [QDEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(QDEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign pop_dat = mem_q[rd_q];

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointers are log2(QDEPTH) wide, so the increment wraps modulo QDEPTH.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || discard) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write controller: clears all N entries after reset, then drains queued updates one per cycle (1 cycle after accept).
// upd_ready drops when the queue is full or the controller is busy; BTB_FLUSH_EN adds flush_req-triggered re-clearing.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter  int N      = 128,
    parameter  int QDEPTH = 4,
    localparam int IW     = btb_idx_w(N),
    localparam int TW     = btb_tag_w(N),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd_valid,
    input  logic [31:0]   upd_pc,
    input  logic [31:0]   upd_target,
    output logic          upd_ready,
    input  logic          flush_req,
    output logic          busy,
    output logic          btb_we,
    output logic [IW-1:0] btb_idx,
    output logic [TW-1:0] btb_tag,
    output logic [31:0]   btb_target,
    output logic          btb_vld
);

    btb_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    btb_upd_t      q_in;
    btb_upd_t      q_head;
    logic          q_push;
    logic          q_pop;
    logic          q_discard;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          unused_bits;

    assign q_in.pc     = upd_pc;
    assign q_in.target = upd_target;

`ifdef BTB_FLUSH_EN
    assign upd_ready   = rst && (state_q == ST_RUN) && !q_full && !flush_req;
    assign unused_bits = ^{q_head.pc[1:0], q_count};
`else
    assign upd_ready   = rst && (state_q == ST_RUN) && !q_full;
    assign unused_bits = ^{q_head.pc[1:0], q_count, flush_req};
`endif

    assign q_push = upd_valid && upd_ready;
    assign busy   = !rst || (state_q != ST_RUN);

    btb_upd_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (q_in),
        .pop      (q_pop),
        .pop_dat  (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count),
        .discard  (q_discard)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        q_pop      = 1'b0;
        q_discard  = 1'b0;
        btb_we     = 1'b0;
        btb_idx    = '0;
        btb_tag    = '0;
        btb_target = '0;
        btb_vld    = 1'b0;
        case (state_q)
`ifdef BTB_FLUSH_EN
            ST_SWEEP, ST_FLUSH: begin
`else
            ST_SWEEP: begin
`endif
                btb_we  = 1'b1;
                btb_idx = idx_q;
                if (idx_q == IW'(N - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_RUN: begin
`ifdef BTB_FLUSH_EN
                // Flush wins over the pending head: it is dropped, not written.
                if (flush_req) begin
                    state_d   = ST_FLUSH;
                    idx_d     = '0;
                    q_discard = 1'b1;
                end else
`endif
                if (!q_empty) begin
                    q_pop      = 1'b1;
                    btb_we     = 1'b1;
                    btb_idx    = q_head.pc[IW+1:2];
                    btb_tag    = q_head.pc[31:IW+2];
                    btb_target = q_head.target;
                    btb_vld    = 1'b1;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                idx_d   = '0;
            end
        endcase
        if (!rst) begin
            q_pop      = 1'b0;
            q_discard  = 1'b0;
            btb_we     = 1'b0;
            btb_idx    = '0;
            btb_tag    = '0;
            btb_target = '0;
            btb_vld    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_SWEEP;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl (N=8 and N=128 instances) and its update queue.
module tb_btb_update_ctrl;
    import btb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // N=8 instance
    logic        a_valid, a_flush, a_ready, a_busy, a_we, a_vld;
    logic [31:0] a_pc, a_tgt, a_target;
    logic [2:0]  a_idx;
    logic [26:0] a_tag;

    // N=128 instance
    logic        b_valid, b_flush, b_ready, b_busy, b_we, b_vld;
    logic [31:0] b_pc, b_tgt, b_target;
    logic [6:0]  b_idx;
    logic [22:0] b_tag;

    // standalone queue
    logic        f_push, f_pop, f_discard, f_full, f_empty;
    btb_upd_t    f_in, f_head;
    logic [2:0]  f_count;

    btb_update_ctrl #(.N(8), .QDEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .upd_valid(a_valid), .upd_pc(a_pc), .upd_target(a_tgt),
        .upd_ready(a_ready), .flush_req(a_flush), .busy(a_busy), .btb_we(a_we),
        .btb_idx(a_idx), .btb_tag(a_tag), .btb_target(a_target), .btb_vld(a_vld)
    );

    btb_update_ctrl #(.N(128), .QDEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .upd_valid(b_valid), .upd_pc(b_pc), .upd_target(b_tgt),
        .upd_ready(b_ready), .flush_req(b_flush), .busy(b_busy), .btb_we(b_we),
        .btb_idx(b_idx), .btb_tag(b_tag), .btb_target(b_target), .btb_vld(b_vld)
    );

    btb_upd_fifo #(.QDEPTH(4)) u_q (
        .clk(clk), .rst(rst), .push(f_push), .push_dat(f_in), .pop(f_pop),
        .pop_dat(f_head), .full(f_full), .empty(f_empty), .count(f_count), .discard(f_discard)
    );

    wire [63:0] a_vec = {a_we, a_idx, a_tag, a_target, a_vld};
    wire [63:0] b_vec = {b_we, b_idx, b_tag, b_target, b_vld};

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 0; a_flush = 0; a_pc = 0; a_tgt = 0;
        b_valid = 0; b_flush = 0; b_pc = 0; b_tgt = 0;
        f_push = 0; f_pop = 0; f_discard = 0; f_in = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({a_we, a_ready, a_busy} !== 3'b001) begin
            errors++; $display("FAIL reset_a we/ready/busy got %b exp 001", {a_we, a_ready, a_busy});
        end
        checks++;
        if ({b_we, b_ready, b_busy} !== 3'b001) begin
            errors++; $display("FAIL reset_b we/ready/busy got %b exp 001", {b_we, b_ready, b_busy});
        end
        checks++;
        if ({f_empty, f_full, f_count} !== 5'b10000) begin
            errors++; $display("FAIL reset_q empty/full/count got %b exp 10000", {f_empty, f_full, f_count});
        end
    endtask

    task automatic sweep_check(input string name);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_vec !== {1'b1, 3'(i), 27'd0, 32'd0, 1'b0} || a_busy !== 1'b1 || a_ready !== 1'b0) begin
                errors++; $display("FAIL %s idx %0d got vec %h busy %b ready %b", name, i, a_vec, a_busy, a_ready);
            end
            @(negedge clk); #1;
        end
        checks++;
        if ({a_busy, a_ready, a_we} !== 3'b010) begin
            errors++; $display("FAIL %s_end busy/ready/we got %b exp 010", name, {a_busy, a_ready, a_we});
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        rst = 1'b1;
        #1;
        sweep_check("sweep");
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs  [5] = '{32'h100, 32'h104, 32'h108, 32'h104, 32'h11C};
        logic [31:0] tgts [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
        logic [2:0]  idxs [5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd7};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5) begin a_valid = 1; a_pc = pcs[k]; a_tgt = tgts[k]; end
            else a_valid = 0;
            #1;
            if (k < 5) begin
                checks++;
                if (a_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready k %0d got %b exp 1", k, a_ready);
                end
            end
            checks++;
            if (k == 0) begin
                if (a_we !== 1'b0) begin
                    errors++; $display("FAIL b2b_nopass got we %b exp 0", a_we);
                end
            end else if (a_vec !== {1'b1, idxs[k-1], 27'h8, tgts[k-1], 1'b1}) begin
                errors++; $display("FAIL b2b_write %0d got %h exp %h", k - 1, a_vec, {1'b1, idxs[k-1], 27'h8, tgts[k-1], 1'b1});
            end
        end
        @(negedge clk); #1;
        checks++;
        if (a_vec !== 64'd0) begin
            errors++; $display("FAIL b2b_drained got %h exp 0", a_vec);
        end
    endtask

    task automatic test_fifo_full();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            f_push = 1; f_in.pc = 32'(k + 1); f_in.target = 32'(k + 100);
        end
        @(negedge clk);
        f_push = 0; #1;
        checks++;
        if ({f_full, f_count, f_head.pc} !== {1'b1, 3'd4, 32'd1}) begin
            errors++; $display("FAIL q_full got full %b count %0d head %0d exp 1 4 1", f_full, f_count, f_head.pc);
        end
        f_push = 1; f_in.pc = 32'd9;
        @(negedge clk);
        f_push = 0; #1;
        checks++;
        if ({f_count, f_head.pc} !== {3'd4, 32'd1}) begin
            errors++; $display("FAIL q_push_at_full got count %0d head %0d exp 4 1", f_count, f_head.pc);
        end
        f_push = 1; f_pop = 1; f_in.pc = 32'd5;
        @(negedge clk);
        f_push = 0; f_pop = 0; #1;
        checks++;
        if ({f_full, f_count, f_head.pc} !== {1'b1, 3'd4, 32'd2}) begin
            errors++; $display("FAIL q_pushpop_full got full %b count %0d head %0d exp 1 4 2", f_full, f_count, f_head.pc);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (f_head.pc !== 32'(k + 2)) begin
                errors++; $display("FAIL q_order %0d got %0d exp %0d", k, f_head.pc, k + 2);
            end
            f_pop = 1;
            @(negedge clk); #1;
        end
        f_pop = 0;
        checks++;
        if ({f_empty, f_count} !== 4'b1000) begin
            errors++; $display("FAIL q_empty got empty %b count %0d exp 1 0", f_empty, f_count);
        end
        f_push = 1; f_in.pc = 32'd7;
        repeat (2) @(negedge clk);
        f_push = 0; f_discard = 1;
        @(negedge clk);
        f_discard = 0; #1;
        checks++;
        if ({f_empty, f_count} !== 4'b1000) begin
            errors++; $display("FAIL q_discard got empty %b count %0d exp 1 0", f_empty, f_count);
        end
    endtask

    task automatic test_decode();
        for (int k = 0; k < 200 && b_busy; k++) @(negedge clk);
        #1;
        checks++;
        if (b_busy !== 1'b0) begin
            errors++; $display("FAIL decode_sweep_timeout busy %b exp 0", b_busy);
        end
        @(negedge clk);
        b_valid = 1; b_pc = 32'h0000_1044; b_tgt = 32'h0000_2000;
        #1;
        checks++;
        if ({b_ready, b_we} !== 2'b10) begin
            errors++; $display("FAIL decode_accept ready/we got %b exp 10", {b_ready, b_we});
        end
        @(negedge clk);
        b_valid = 0; #1;
        checks++;
        if (b_vec !== {1'b1, 7'h11, 23'h8, 32'h2000, 1'b1}) begin
            errors++; $display("FAIL decode_write got %h exp %h", b_vec, {1'b1, 7'h11, 23'h8, 32'h2000, 1'b1});
        end
        @(negedge clk); #1;
        checks++;
        if (b_vec !== 64'd0) begin
            errors++; $display("FAIL decode_idle got %h exp 0", b_vec);
        end
    endtask

`ifdef BTB_FLUSH_EN
    task automatic test_flush();
        @(negedge clk);
        a_valid = 1; a_pc = 32'h100; a_tgt = 32'h1000;
        @(negedge clk);
        a_valid = 0; a_flush = 1; #1;
        checks++;
        if ({a_we, a_ready} !== 2'b00) begin
            errors++; $display("FAIL flush_head we/ready got %b exp 00", {a_we, a_ready});
        end
        @(negedge clk);
        a_flush = 0; #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_vec !== {1'b1, 3'(i), 27'd0, 32'd0, 1'b0} || a_busy !== 1'b1) begin
                errors++; $display("FAIL flush_idx %0d got vec %h busy %b", i, a_vec, a_busy);
            end
            a_flush = (i == 3);
            @(negedge clk); #1;
        end
        a_flush = 0;
        checks++;
        if ({a_busy, a_ready, a_we} !== 3'b010) begin
            errors++; $display("FAIL flush_end busy/ready/we got %b exp 010", {a_busy, a_ready, a_we});
        end
        @(negedge clk); #1;
        checks++;
        if (a_we !== 1'b0) begin
            errors++; $display("FAIL flush_discard we got %b exp 0", a_we);
        end
    endtask
`else
    task automatic test_no_flush();
        @(negedge clk);
        a_valid = 1; a_pc = 32'h104; a_tgt = 32'h7000; a_flush = 1; #1;
        checks++;
        if ({a_ready, a_busy} !== 2'b10) begin
            errors++; $display("FAIL noflush_ready ready/busy got %b exp 10", {a_ready, a_busy});
        end
        @(negedge clk);
        a_valid = 0; #1;
        checks++;
        if (a_vec !== {1'b1, 3'd1, 27'h8, 32'h7000, 1'b1}) begin
            errors++; $display("FAIL noflush_write got %h exp %h", a_vec, {1'b1, 3'd1, 27'h8, 32'h7000, 1'b1});
        end
        @(negedge clk);
        a_flush = 0; #1;
        checks++;
        if ({a_busy, a_we} !== 2'b00) begin
            errors++; $display("FAIL noflush_idle busy/we got %b exp 00", {a_busy, a_we});
        end
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk);
        a_valid = 1; a_pc = 32'h108; a_tgt = 32'h3000;
        @(negedge clk);
        a_valid = 0; rst = 0; #1;
        checks++;
        if ({a_we, a_busy, a_ready} !== 3'b010) begin
            errors++; $display("FAIL rstq we/busy/ready got %b exp 010", {a_we, a_busy, a_ready});
        end
        @(negedge clk);
        rst = 1; #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (a_vec !== {1'b1, 3'(i), 27'd0, 32'd0, 1'b0}) begin
                errors++; $display("FAIL rstq_sweep idx %0d got %h", i, a_vec);
            end
            if (i < 5) begin @(negedge clk); #1; end
        end
        rst = 0;
        @(negedge clk); #1;
        checks++;
        if ({a_we, a_busy, a_ready} !== 3'b010) begin
            errors++; $display("FAIL rstmid we/busy/ready got %b exp 010", {a_we, a_busy, a_ready});
        end
        rst = 1; #1;
        sweep_check("rstmid_sweep");
        @(negedge clk); #1;
        checks++;
        if (a_we !== 1'b0) begin
            errors++; $display("FAIL rstmid_queue_empty we got %b exp 0", a_we);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sweep();
        test_back_to_back();
        test_fifo_full();
        test_decode();
`ifdef BTB_FLUSH_EN
        test_flush();
`else
        test_no_flush();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
